// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues word fetches, buffers responses in a prefetch queue.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module instr_fetch #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc, resp_pc, target_pc;
    logic [31:0]       q_word [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, outstanding, discard, cnt_left;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic              issue, push, pop, credit_ok;

    assign target_pc = redirect_pc & ALIGN_MASK;

    // Credits count in-flight requests against free queue slots so a push never overflows.
    assign credit_ok = (outstanding < CW'(MAX_OUTST)) &&
                       (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign imem_req  = !reset && fetch_en && !redirect && credit_ok;
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign push        = imem_rvalid && (discard == '0) && !redirect;
    assign cnt_left    = count - CW'(pop);

    assign instruction = instr_q;
    assign instr_pc    = pc_q;

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            q_word[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            instr_q     <= 32'h0;
            pc_q        <= RESET_PC;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
            if (redirect) begin
                // A response landing in the redirect cycle is already dropped here.
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding - CW'(imem_rvalid);
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                if (imem_rvalid && discard != '0)
                    discard <= discard - CW'(1);
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + ADDR_W'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= cnt_left + CW'(push);
                // Output registers track the next head; they hold when the queue runs dry.
                if (cnt_left != '0) begin
                    instr_q <= q_word[rd_ptr + PW'(pop)];
                    pc_q    <= q_pc[rd_ptr + PW'(pop)];
                end else if (push) begin
                    instr_q <= imem_rdata;
                    pc_q    <= resp_pc;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (instr_ready && !instr_valid && !redirect && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'h1;
            if (redirect && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'h1;
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed table, corner sequences, then random traffic vs an epoch-based model.
module tb_instr_fetch;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clock = 0, reset = 1, fetch_en = 0, redirect = 0;
    logic        imem_gnt = 0, imem_rvalid = 0, instr_ready = 0;
    logic [31:0] redirect_pc = 0, imem_rdata = 0;
    wire         imem_req, instr_valid;
    wire  [31:0] imem_addr, instruction, instr_pc;
`ifdef FETCH_PERF_CNT_EN
    wire  [31:0] stall_cnt, flush_cnt;
`endif

    instr_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
        .clock(clock), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;
    typedef struct { bit rdy; bit req; logic [31:0] addr; bit vld; logic [31:0] pc; } vec_t;

    // Model: in-flight requests carry a stale flag set by redirect; live responses join the queue.
    mreq_t       mem_q[$];
    ent_t        exp_q[$];
    logic [31:0] fetch_pc_m = RESET_PC;
    logic [31:0] seen[$];
    vec_t        tbl[21];
    int          vectors = 0, miscompares = 0, cyc = 0;
    int          lat_min = 1, lat_max = 1, rv_pct = 100;
    bit          mem_hold = 0, chk_en = 0, rv, m_req;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply(input bit rst, input bit fe, input bit rd, input logic [31:0] rpc,
                         input bit g, input bit rdy);
        @(negedge clock);
        reset = rst; fetch_en = fe; redirect = rd; redirect_pc = rpc;
        imem_gnt = g; instr_ready = rdy;
        rv = !rst && mem_q.size() != 0 && !mem_hold && mem_q[0].due <= cyc &&
             ($urandom_range(99) < rv_pct);
        imem_rvalid = rv;
        imem_rdata  = rv ? word_of(mem_q[0].addr) : $urandom;
        m_req = !rst && fe && !rd && mem_q.size() < MAX_OUTST &&
                (exp_q.size() + mem_q.size()) < DEPTH;
        #1;
        if (chk_en) begin
            check("imem_req", 32'(imem_req), 32'(m_req));
            if (m_req) check("imem_addr", imem_addr, fetch_pc_m);
            check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("instr_pc", instr_pc, exp_q[0].pc);
                check("instruction", instruction, exp_q[0].word);
            end
        end
    endtask

    task automatic commit();
        mreq_t r;
        ent_t  dummy;
        if (reset) begin
            mem_q.delete();
            exp_q.delete();
            fetch_pc_m = RESET_PC;
        end else begin
            if (rv) r = mem_q.pop_front();
            if (redirect) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                exp_q.delete();
                fetch_pc_m = redirect_pc & ~32'h3;
            end else begin
                if (instr_ready && exp_q.size() != 0) dummy = exp_q.pop_front();
                if (rv && !r.stale) exp_q.push_back('{word_of(r.addr), r.addr});
            end
            if (m_req && imem_gnt) begin
                mem_q.push_back('{fetch_pc_m, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
                fetch_pc_m += 32'h4;
            end
        end
        cyc++;
    endtask

    task automatic cycle(input bit rst, input bit fe, input bit rd, input logic [31:0] rpc,
                         input bit g, input bit rdy);
        apply(rst, fe, rd, rpc, g, rdy);
        commit();
    endtask

    task automatic reset_dut();
        cycle(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_instruction", instruction, 0);
        check("rst_instr_pc", instr_pc, RESET_PC);
        commit();
    endtask

    task automatic run_collect(input int n, input bit g);
        for (int i = 0; i < n; i++) begin
            apply(0, 1, 0, 0, g, 1);
            if (instr_valid) seen.push_back(instr_pc);
            commit();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Hand-derived trace: 1-cycle memory, fill and stream, then 10 cycles of back-pressure.
        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[7]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        for (int i = 9; i <= 15; i++) tbl[i] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[16] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[17] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        tbl[18] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
        tbl[19] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
        tbl[20] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

        cycle(1, 0, 0, 0, 0, 0);
        chk_en = 1;
        reset_dut();
        for (int i = 0; i < 21; i++) begin
            apply(0, 1, 0, 0, 1, tbl[i].rdy);
            check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            if (tbl[i].req) check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                check($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
                check($sformatf("tbl%0d_word", i), instruction, word_of(tbl[i].pc));
            end
            commit();
        end

        // Two outstanding (0x10, 0x14), redirect to 0x103.
        reset_dut();
        cycle(0, 1, 1, 32'h10, 1, 1);
        mem_hold = 1;
        cycle(0, 1, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 1, 1);
        apply(0, 1, 0, 0, 1, 1);
        check("a_req_blocked", 32'(imem_req), 0);
        commit();
        apply(0, 1, 1, 32'h103, 1, 1);
        check("a_redirect_req", 32'(imem_req), 0);
        commit();
        mem_hold = 0;
        seen.delete();
        run_collect(20, 1);
        check("a_count_ok", 32'(seen.size() >= 2), 1);
        if (seen.size() >= 2) begin
            check("a_first_pc", seen[0], 32'h100);
            check("a_second_pc", seen[1], 32'h104);
        end

        // Response for 0x20 lands in the redirect cycle, 0x24 still in flight.
        reset_dut();
        cycle(0, 1, 1, 32'h20, 1, 1);
        mem_hold = 1;
        cycle(0, 1, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 1, 1);
        mem_hold = 0;
        apply(0, 1, 1, 32'h200, 1, 1);
        check("b_rsp_in_redirect", 32'(imem_rvalid), 1);
        check("b_redirect_req", 32'(imem_req), 0);
        commit();
        seen.delete();
        run_collect(20, 1);
        check("b_count_ok", 32'(seen.size() >= 1), 1);
        if (seen.size() >= 1) check("b_first_pc", seen[0], 32'h200);
        begin
            int stale_hits = 0;
            foreach (seen[i]) if (seen[i] == 32'h20 || seen[i] == 32'h24) stale_hits++;
            check("b_stale_words", stale_hits, 0);
        end

        // PC wrap at the top of the address space; grant withheld 5 cycles.
        reset_dut();
        cycle(0, 1, 1, 32'hFFFF_FFFF, 0, 1);
        seen.delete();
        apply(0, 1, 0, 0, 1, 1);
        check("c_addr_top", imem_addr, 32'hFFFF_FFFC);
        commit();
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, 0, 0, 1);
            check("c_req_held", 32'(imem_req), 1);
            check("c_addr_wrap", imem_addr, 32'h0);
            if (instr_valid) seen.push_back(instr_pc);
            commit();
        end
        run_collect(6, 1);
        check("c_count_ok", 32'(seen.size() >= 3), 1);
        if (seen.size() >= 3) begin
            check("c_pc0", seen[0], 32'hFFFF_FFFC);
            check("c_pc1", seen[1], 32'h0);
            check("c_pc2", seen[2], 32'h4);
        end

        // Reset with a loaded queue and requests in flight.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 1, 0);
        check("d_loaded", 32'(instr_valid), 1);
        reset_dut();
        apply(0, 1, 0, 0, 1, 1);
        check("d_restart_req", 32'(imem_req), 1);
        check("d_restart_addr", imem_addr, RESET_PC);
        commit();

        // Random traffic against the model.
        lat_min = 1; lat_max = 3; rv_pct = 75;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(299) == 0, $urandom_range(9) != 0, $urandom_range(32) == 0,
                  $urandom, $urandom_range(9) < 7, $urandom_range(9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream stage of the datapath. Owns the program counter and issues word fetches to instruction memory.
- Buffers returned words in a small prefetch queue and presents one 32-bit instruction per cycle to the datapath's `instruction` input under a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- ADDR_W, 32, byte-address width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, prefetch queue entries (power of 2, >= 2).
- MAX_OUTST, 2, maximum outstanding memory requests (<= DEPTH).

Ports:
- clock, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous, active-high reset.
- fetch_en, input, 1, allows new requests; when low, no new requests issue and in-flight responses still complete.
- redirect, input, 1, one-cycle pulse; load redirect_pc and flush.
- redirect_pc, input, ADDR_W, new fetch address; bits [1:0] ignored and forced to 0.
- imem_req, output, 1, request valid.
- imem_addr, output, ADDR_W, word-aligned request address.
- imem_gnt, input, 1, memory accepts the request this cycle (req && gnt = issue).
- imem_rvalid, input, 1, response valid; responses return in order, >= 1 cycle after issue.
- imem_rdata, input, 32, response word.
- instruction, output, 32, head-of-queue word; drives datapath `instruction`.
- instr_pc, output, ADDR_W, address of `instruction`.
- instr_valid, output, 1, head entry valid.
- instr_ready, input, 1, datapath consumes head (valid && ready = pop).

Behaviour:
- Reset (synchronous, active-high; clock and reset are the only timing/reset sources): fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0, imem_req=0, instr_valid=0, instruction=32'h0 (NOP opcode), instr_pc=RESET_PC.
  - Reset asserted mid-operation overrides everything. Responses arriving after reset deasserts that belong to pre-reset requests are the memory's responsibility; memory must be reset on the same edge.
- Credit: imem_req = fetch_en && !redirect && (outstanding < MAX_OUTST) && (count + outstanding < DEPTH). imem_addr = fetch_pc.
- Issue: on req && gnt, fetch_pc += 4 (wraps modulo 2^ADDR_W) and outstanding++. Each queued entry stores {word, pc}; pc is tracked via a resp_pc register, advanced by 4 per accepted response.
- Response: on rvalid, outstanding--.
  - If discard > 0: discard-- and drop the word.
  - Otherwise push {imem_rdata, resp_pc}.
  - The credit rule guarantees the queue never overflows.
- Pop: on instr_valid && instr_ready, head advances. Push and pop in the same cycle are legal, including when full (count unchanged) and when empty (the pushed word becomes head next cycle, no bypass; latency from rvalid to instr_valid is 1 cycle).
- instruction and instr_pc are registered outputs of the head entry. They hold their value while instr_valid && !instr_ready, and read 0 / last value when empty.
- Redirect (highest priority after reset), in the same cycle:
  - Queue flushed (count=0, instr_valid=0 next cycle).
  - fetch_pc = resp_pc = {redirect_pc[ADDR_W-1:2],2'b00}.
  - discard = outstanding minus (1 if rvalid this cycle else 0). A response arriving in the redirect cycle is itself dropped.
  - imem_req forced 0 in the redirect cycle.
  - Pop in the redirect cycle is ignored; no counting of it is required of the datapath.
- fetch_en low: queue keeps draining and filling from in-flight responses; fetch_pc holds.
- Back-to-back redirects: the later one wins; discard is recomputed from the current outstanding.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] (cycles with instr_ready && !instr_valid && !redirect) and flush_cnt[31:0] (redirect pulses). Both reset to 0, saturate at 32'hFFFF_FFFF, and are not cleared by redirect.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, fetch_en=1, gnt=1, rdata=address, 1-cycle memory, ready=1 -> instr_pc sequence 0,4,8,C... with instruction==instr_pc, one per cycle after fill.
- ready=0 for 10 cycles -> exactly DEPTH=4 entries accepted, imem_req drops to 0, head holds pc 0; ready=1 -> 0,4,8,C then 10 with no gaps or duplicates.
- Two requests outstanding (0x10, 0x14), redirect to 0x103 -> both responses dropped, next instr_pc = 0x100, then 0x104.
- Redirect in the same cycle as rvalid for 0x20 with 1 other outstanding -> discard=1, the 0x20 word never appears, first output is the redirect target.
- fetch_pc = 0xFFFF_FFFC -> next request 0x0000_0000; gnt held low 5 cycles -> imem_addr stable, no duplicate issue.
- Reset asserted with a full queue and outstanding=2 -> next cycle instr_valid=0, imem_req=0, instruction=0; after release, fetch restarts at RESET_PC.
